// File: rtl/console_arbiter.sv
// console_arbiter: hands the keypad stream and display to one of N_SRC client FSMs at a time.
module console_arbiter #(
  parameter int N_SRC = 2,
  parameter int DIGITS = 6,
  parameter int IDLE_TIMEOUT = 30000,
  parameter int DEFAULT_SRC = 0,
  parameter logic [3:0] BLANK = 4'hF,
  localparam int W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SRC-1:0]          req,
  input  logic [N_SRC-1:0]          rel,
  input  logic [N_SRC*DIGITS*4-1:0] src_bcd,
  input  logic [N_SRC-1:0]          src_bcd_en,
  input  logic                      key_valid,
  input  logic [3:0]                key_code,
  output logic [N_SRC-1:0]          key_valid_o,
  output logic [3:0]                key_code_o,
  output logic [DIGITS*4-1:0]       bcd_out,
  output logic                      bcd_enable,
  output logic [N_SRC-1:0]          grant,
  output logic [W-1:0]              owner,
  output logic                      timeout
);
  localparam int TW = $clog2(IDLE_TIMEOUT);
  localparam logic [0:0] OWN = 1'b0, HANDOVER = 1'b1;
  localparam logic [W-1:0] DEF = W'(DEFAULT_SRC);
  localparam logic [TW-1:0] TMAX = TW'(IDLE_TIMEOUT - 1);
  logic [0:0] state;
  logic [W-1:0] nxt, pick;
  logic [TW-1:0] timer;
  logic [N_SRC-1:0] own_oh, others;
  logic is_def, in_own, rel_go, to_go, req_go, go;
  assign own_oh = N_SRC'(1) << owner;
  assign others = req & ~own_oh;
  assign is_def = owner == DEF;
  assign in_own = state == OWN;
  assign rel_go = in_own && !is_def && |(rel & own_oh);
  assign to_go = in_own && !is_def && timer == TMAX && !key_valid && !rel_go;
  assign req_go = in_own && is_def && |others;
  assign go = rel_go || to_go || req_go;
  // Descending scan so the lowest waiting index wins; default when nobody waits.
  always_comb begin
    pick = DEF;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (others[i]) pick = W'(i);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= OWN;
      owner <= DEF;
      nxt <= DEF;
      grant <= N_SRC'(1) << DEF;
      timer <= '0;
      timeout <= 1'b0;
      key_valid_o <= '0;
      key_code_o <= '0;
      bcd_out <= {DIGITS{BLANK}};
      bcd_enable <= 1'b0;
    end else begin
      state <= go ? HANDOVER : OWN;
      if (go) nxt <= to_go ? DEF : pick;
      if (!in_own) owner <= nxt;
      grant <= go ? '0 : !in_own ? N_SRC'(1) << nxt : grant;
      timeout <= to_go;
      timer <= (!in_own || is_def || key_valid || go) ? '0 : (timer == TMAX) ? timer : timer + 1'b1;
      key_valid_o <= (in_own && key_valid) ? own_oh : '0;
      if (in_own && key_valid) key_code_o <= key_code;
      bcd_out <= (in_own && !go) ? src_bcd[int'(owner)*DIGITS*4 +: DIGITS*4] : {DIGITS{BLANK}};
      bcd_enable <= in_own && !go && src_bcd_en[owner];
    end
  end
endmodule

// File: tb/tb_console_arbiter.sv
// tb_console_arbiter: directed scenarios plus randomized run against a behavioural ownership model.
module tb_console_arbiter;
  logic clk = 0, rst = 0;
  logic [2:0] req = 0, rel = 0, src_bcd_en = 3'b111;
  logic [71:0] src_bcd = {24'h123456, 24'h654321, 24'h111111};
  logic key_valid = 0;
  logic [3:0] key_code = 0;
  logic [2:0] key_valid_o, grant;
  logic [3:0] key_code_o;
  logic [23:0] bcd_out;
  logic bcd_enable, timeout;
  logic [1:0] owner;
  int checks = 0, errors = 0;

  console_arbiter #(.N_SRC(3), .DIGITS(6), .IDLE_TIMEOUT(10), .DEFAULT_SRC(0), .BLANK(4'hF)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .src_bcd(src_bcd), .src_bcd_en(src_bcd_en),
    .key_valid(key_valid), .key_code(key_code), .key_valid_o(key_valid_o), .key_code_o(key_code_o),
    .bcd_out(bcd_out), .bcd_enable(bcd_enable), .grant(grant), .owner(owner), .timeout(timeout));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) step();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL reset_grant got %b exp 001", grant); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", owner); end
    checks++; if (bcd_enable !== 1'b0) begin errors++; $display("FAIL reset_bcd_en got %b exp 0", bcd_enable); end
    checks++; if (bcd_out !== 24'hFFFFFF) begin errors++; $display("FAIL reset_bcd got %h exp ffffff", bcd_out); end
    checks++; if (key_valid_o !== 3'b000 || timeout !== 1'b0 || key_code_o !== 4'h0)
      begin errors++; $display("FAIL reset_keys got kvo=%b to=%b code=%h exp 000/0/0", key_valid_o, timeout, key_code_o); end
    rst = 1;
    step();
    checks++; if (bcd_out !== 24'h111111 || bcd_enable !== 1'b1)
      begin errors++; $display("FAIL default_display got %h/%b exp 111111/1", bcd_out, bcd_enable); end
  endtask

  task automatic test_request_routing();
    req = 3'b100;
    step();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL req_handover_grant got %b exp 000", grant); end
    checks++; if (bcd_enable !== 1'b0 || bcd_out !== 24'hFFFFFF)
      begin errors++; $display("FAIL req_handover_blank got %h/%b exp ffffff/0", bcd_out, bcd_enable); end
    req = 0;
    step();
    checks++; if (grant !== 3'b100 || owner !== 2'd2) begin errors++; $display("FAIL req_grant got %b/%0d exp 100/2", grant, owner); end
    key_valid = 1; key_code = 4'h5;
    step();
    key_valid = 0;
    checks++; if (key_valid_o !== 3'b100 || key_code_o !== 4'h5)
      begin errors++; $display("FAIL key_route got %b/%h exp 100/5", key_valid_o, key_code_o); end
    checks++; if (bcd_out !== 24'h123456 || bcd_enable !== 1'b1)
      begin errors++; $display("FAIL owner_display got %h/%b exp 123456/1", bcd_out, bcd_enable); end
    step();
    checks++; if (key_valid_o !== 3'b000 || key_code_o !== 4'h5)
      begin errors++; $display("FAIL key_hold got %b/%h exp 000/5", key_valid_o, key_code_o); end
  endtask

  task automatic test_release_waiting();
    rel = 3'b100; req = 3'b010;
    step();
    rel = 0;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rel_handover got %b exp 000", grant); end
    step();
    checks++; if (grant !== 3'b010 || owner !== 2'd1) begin errors++; $display("FAIL rel_waiting got %b/%0d exp 010/1", grant, owner); end
    req = 3'b100;
    step();
    req = 0;
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL no_preempt got %b exp 010", grant); end
  endtask

  task automatic test_key_handover();
    rel = 3'b010; req = 3'b100;
    step();
    rel = 0; req = 0; key_valid = 1; key_code = 4'h9;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL kh_handover got %b exp 000", grant); end
    step();
    key_valid = 0;
    checks++; if (key_valid_o !== 3'b000) begin errors++; $display("FAIL kh_dropped got %b exp 000", key_valid_o); end
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL kh_grant got %b exp 100", grant); end
    step();
    checks++; if (key_valid_o !== 3'b000 || key_code_o !== 4'h5)
      begin errors++; $display("FAIL kh_code got %b/%h exp 000/5", key_valid_o, key_code_o); end
  endtask

  task automatic test_timeout();
    key_valid = 1; key_code = 4'h3;
    step();
    key_valid = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++; if (timeout !== (i == 10)) begin errors++; $display("FAIL timeout_pulse k+%0d got %b exp %b", i, timeout, i == 10); end
    end
    step();
    checks++; if (timeout !== 1'b0 || grant !== 3'b001 || owner !== 2'd0)
      begin errors++; $display("FAIL timeout_default got %b/%b/%0d exp 0/001/0", timeout, grant, owner); end
  endtask

  task automatic test_key_restart();
    req = 3'b010;
    step();
    req = 0;
    step();
    key_valid = 1; key_code = 4'h1;
    step();
    key_valid = 0;
    for (int i = 1; i <= 19; i++) begin
      key_valid = (i == 9);
      step();
      key_valid = 0;
      checks++; if (timeout !== (i == 19)) begin errors++; $display("FAIL restart_pulse k+%0d got %b exp %b", i, timeout, i == 19); end
    end
    step();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL restart_default got %b exp 001", grant); end
  endtask

  task automatic test_reset_mid_handover();
    req = 3'b100;
    step();
    req = 0;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rmh_handover got %b exp 000", grant); end
    rst = 0;
    step();
    checks++; if (grant !== 3'b001 || owner !== 2'd0 || bcd_enable !== 1'b0)
      begin errors++; $display("FAIL rmh_reset got %b/%0d/%b exp 001/0/0", grant, owner, bcd_enable); end
    rst = 1;
    repeat (2) step();
    checks++; if (grant !== 3'b001 || owner !== 2'd0) begin errors++; $display("FAIL rmh_no_grant got %b/%0d exp 001/0", grant, owner); end
  endtask

  function automatic int lowest(input logic [2:0] r, input int excl);
    for (int i = 0; i < 3; i++) if (r[i] && i != excl) return i;
    return 0;
  endfunction

  task automatic test_random();
    int m_owner, m_next, m_idle;
    bit m_ho, go, to;
    logic [3:0] m_code;
    logic [2:0] e_kvo, e_grant;
    logic [23:0] e_bcd;
    logic e_en;
    rst = 0; step(); rst = 1;
    m_owner = 0; m_next = 0; m_idle = 0; m_ho = 0; m_code = 0;
    for (int c = 0; c < 600; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      rel = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      key_valid = ($urandom_range(0, (c / 100) % 2 ? 15 : 2) == 0);
      key_code = 4'($urandom);
      src_bcd = {$urandom, $urandom, $urandom};
      src_bcd_en = 3'($urandom);
      go = 0; to = 0;
      e_kvo = (!m_ho && key_valid) ? 3'b001 << m_owner : 3'b000;
      if (!m_ho && key_valid) m_code = key_code;
      e_bcd = 24'hFFFFFF; e_en = 0;
      if (m_ho) begin
        m_ho = 0; m_owner = m_next; m_idle = 0;
      end else begin
        if (m_owner != 0 && rel[m_owner]) begin go = 1; m_next = lowest(req, m_owner); end
        else if (m_owner != 0 && m_idle == 9 && !key_valid) begin go = 1; to = 1; m_next = 0; end
        else if (m_owner == 0 && (req & 3'b110) != 0) begin go = 1; m_next = lowest(req, 0); end
        if (!go) begin e_bcd = src_bcd[m_owner*24 +: 24]; e_en = src_bcd_en[m_owner]; end
        m_idle = (key_valid || m_owner == 0) ? 0 : (m_idle < 9 ? m_idle + 1 : 9);
        m_ho = go;
      end
      e_grant = m_ho ? 3'b000 : 3'b001 << m_owner;
      step();
      checks++;
      if (grant !== e_grant || owner !== 2'(m_owner) || timeout !== to || key_valid_o !== e_kvo ||
          key_code_o !== m_code || bcd_out !== e_bcd || bcd_enable !== e_en) begin
        errors++;
        $display("FAIL random c=%0d got g=%b o=%0d to=%b kv=%b kc=%h bcd=%h en=%b exp g=%b o=%0d to=%b kv=%b kc=%h bcd=%h en=%b",
          c, grant, owner, timeout, key_valid_o, key_code_o, bcd_out, bcd_enable,
          e_grant, m_owner, to, e_kvo, m_code, e_bcd, e_en);
      end
    end
    req = 0; rel = 0; key_valid = 0;
  endtask

  initial begin
    test_reset();
    test_request_routing();
    test_release_waiting();
    test_key_handover();
    test_timeout();
    test_key_restart();
    test_reset_mid_handover();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
